// File: rtl/dut_result_checker.sv
// Compares each dut result against its golden result, counts mismatches, keeps the
// first failing vector and folds the dut stream into a MISR signature.
module dut_result_checker #(
  parameter int                WIDTH = 80,
  parameter int                CNT_W = 16,
  parameter logic [WIDTH-1:0]  POLY  = 'h9,
  parameter logic [WIDTH-1:0]  SEED  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vectors,
  input  logic             res_valid,
  input  logic [WIDTH-1:0] res_data,
  output logic             res_ready,
  input  logic             exp_valid,
  input  logic [WIDTH-1:0] exp_data,
  output logic             exp_ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic [WIDTH-1:0] first_fail_diff,
  output logic [WIDTH-1:0] signature
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0] target;
  logic [CNT_W-1:0] accepted;
  logic             stage_valid;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] diff_q;
  logic [CNT_W-1:0] idx_q;
  logic             start_acc;
  logic             hs;

  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign pass      = done && (mismatch_cnt == '0);
  assign start_acc = start && (state != RUN);
  assign hs        = busy && res_valid && exp_valid && (accepted < target);
  assign res_ready = hs;
  assign exp_ready = hs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // RUN only ends once every accepted vector has also drained through stage 2
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if ((accepted == target) && !stage_valid) state_nxt = DONE;
      DONE:    if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target          <= '0;
      accepted        <= '0;
      stage_valid     <= 1'b0;
      res_q           <= '0;
      diff_q          <= '0;
      idx_q           <= '0;
      mismatch_cnt    <= '0;
      first_fail_idx  <= '0;
      first_fail_diff <= '0;
      signature       <= SEED;
    end else if (start_acc) begin
      target          <= num_vectors;
      accepted        <= '0;
      stage_valid     <= 1'b0;
      mismatch_cnt    <= '0;
      first_fail_idx  <= '0;
      first_fail_diff <= '0;
      signature       <= SEED;
    end else begin
      stage_valid <= hs;
      if (hs) begin
        res_q    <= res_data;
        diff_q   <= res_data ^ exp_data;
        idx_q    <= accepted;
        accepted <= accepted + CNT_W'(1);
      end
      // A zero count means no mismatch has been captured yet, so the first one wins
      if (stage_valid) begin
        signature <= {signature[WIDTH-2:0], 1'b0}
                     ^ (signature[WIDTH-1] ? POLY : '0)
                     ^ res_q;
        if (diff_q != '0) begin
          if (mismatch_cnt != '1) mismatch_cnt <= mismatch_cnt + CNT_W'(1);
          if (mismatch_cnt == '0) begin
            first_fail_idx  <= idx_q;
            first_fail_diff <= diff_q;
          end
        end
      end
    end
  end

endmodule
